// File: rtl/ysyx_24100027_imm_enc.sv
// ysyx_24100027_imm_enc: two-stage RISC-V immediate encoder with valid/ready on both ports.
// S1 holds the raw request; S2 holds the packed instruction and its range/alignment error flag.
module ysyx_24100027_imm_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_extop,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] enc_cnt,
    output logic [15:0] err_cnt
);
    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_U = 3'd1;
    localparam logic [2:0] EXT_S = 3'd2;
    localparam logic [2:0] EXT_B = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;

    function automatic logic [31:0] pack_imm(input logic [2:0]  extop,
                                             input logic [31:0] imm,
                                             input logic [31:0] base);
        logic [31:0] inst;
        case (extop)
            EXT_I:   inst = {imm[11:0], base[19:0]};
            EXT_U:   inst = {imm[31:12], base[11:0]};
            EXT_S:   inst = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            EXT_B:   inst = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            EXT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            default: inst = base;
        endcase
        return inst;
    endfunction

    // An immediate is legal only if it survives truncation to its field width (and is even for branches/jumps).
    function automatic logic imm_err(input logic [2:0] extop, input logic [31:0] imm);
        logic err;
        case (extop)
            EXT_I, EXT_S: err = (imm != {{20{imm[11]}}, imm[11:0]});
            EXT_U:        err = (imm[11:0] != 12'h000);
            EXT_B:        err = imm[0] | (imm != {{19{imm[12]}}, imm[12:0]});
            EXT_J:        err = imm[0] | (imm != {{11{imm[20]}}, imm[20:0]});
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

    logic        s1_valid_r;
    logic [2:0]  s1_extop_r;
    logic [31:0] s1_imm_r;
    logic [31:0] s1_base_r;
    logic        s2_valid_r;
    logic [31:0] s2_inst_r;
    logic        s2_err_r;
    logic [15:0] enc_cnt_r;
    logic [15:0] err_cnt_r;

    logic        in_ready_s;
    logic        in_hs_s;
    logic        out_hs_s;
    logic        s2_load_s;
    logic [31:0] enc_inst_s;
    logic        enc_err_s;

    // Handshake decode and encoding of the request currently held in S1.
    always_comb begin
        in_ready_s = 1'b0;
        in_hs_s    = 1'b0;
        out_hs_s   = 1'b0;
        s2_load_s  = 1'b0;
        enc_inst_s = 32'h0000_0000;
        enc_err_s  = 1'b0;
        in_ready_s = !s1_valid_r || (!s2_valid_r || out_ready);
        in_hs_s    = in_valid && in_ready_s;
        out_hs_s   = s2_valid_r && out_ready;
        s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
        enc_inst_s = pack_imm(s1_extop_r, s1_imm_r, s1_base_r);
        enc_err_s  = imm_err(s1_extop_r, s1_imm_r);
    end

    // Pipeline stages; S2 holds its result while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_extop_r <= 3'd0;
            s1_imm_r   <= 32'h0000_0000;
            s1_base_r  <= 32'h0000_0000;
            s2_valid_r <= 1'b0;
            s2_inst_r  <= 32'h0000_0000;
            s2_err_r   <= 1'b0;
        end else begin
            if (in_hs_s) begin
                s1_valid_r <= 1'b1;
                s1_extop_r <= in_extop;
                s1_imm_r   <= in_imm;
                s1_base_r  <= in_base;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s2_load_s) begin
                s2_valid_r <= 1'b1;
                s2_inst_r  <= enc_inst_s;
                s2_err_r   <= enc_err_s;
            end else if (out_ready) begin
                s2_valid_r <= 1'b0;
            end
        end
    end

    // Saturating output-handshake counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_cnt_r <= 16'h0000;
            err_cnt_r <= 16'h0000;
        end else begin
            if (out_hs_s && (enc_cnt_r != 16'hFFFF)) begin
                enc_cnt_r <= enc_cnt_r + 16'h0001;
            end
            if (out_hs_s && s2_err_r && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'h0001;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign out_inst  = s2_inst_r;
    assign out_err   = s2_err_r;
    assign enc_cnt   = enc_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_ysyx_24100027_imm_enc.sv
// Bench for ysyx_24100027_imm_enc: arithmetic reference model with an in-flight queue,
// checked every cycle, plus hand-computed literal vectors.
module tb_ysyx_24100027_imm_enc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_extop;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;

    ysyx_24100027_imm_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_extop(in_extop), .in_imm(in_imm), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; logic err; int acc; } exp_t;
    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] m_enc = 16'h0000;
    logic [15:0] m_err = 16'h0000;

    // Reference: field placement by shifting/masking, legality by signed range checks.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] base);
        longint s;
        logic [31:0] inst;
        logic err;
        s = longint'($signed(imm));
        case (op)
            3'd0: begin
                inst = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
                err  = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                inst = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
                err  = (imm % 4096) != 0;
            end
            3'd2: begin
                inst = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                err  = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                inst = (base & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
                err  = ((imm % 2) != 0) || (s < -4096) || (s > 4095);
            end
            3'd4: begin
                inst = (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
                err  = ((imm % 2) != 0) || (s < -1048576) || (s > 1048575);
            end
            default: begin
                inst = base;
                err  = 1'b1;
            end
        endcase
        return {err, inst};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Per-cycle compare: the oldest in-flight item must be on the output once it is 2 edges old.
    task automatic monitor();
        bit armed = 1'b0;
        logic [32:0] m;
        forever begin
            @(negedge clk);
            cyc++;
            if (armed) begin
                chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0) && ((cyc - q[0].acc) >= 2)});
                if (out_valid && (q.size() > 0)) begin
                    chk("out_inst", out_inst, q[0].inst);
                    chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
                end
                chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
                chk("enc_cnt", {16'd0, enc_cnt}, {16'd0, m_enc});
                chk("err_cnt", {16'd0, err_cnt}, {16'd0, m_err});
            end
            if (rst) begin
                q.delete();
                m_enc = 16'h0000;
                m_err = 16'h0000;
                armed = 1'b1;
            end else if (armed) begin
                if (out_valid && out_ready && (q.size() > 0)) begin
                    if (m_enc != 16'hFFFF) m_enc++;
                    if (q[0].err && (m_err != 16'hFFFF)) m_err++;
                    void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    m = model(in_extop, in_imm, in_base);
                    q.push_back('{m[31:0], m[32], cyc});
                end
            end
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] base);
        int t = 0;
        in_valid = 1'b1;
        in_extop = op;
        in_imm   = imm;
        in_base  = base;
        @(negedge clk);
        while (!in_ready && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        chk("send_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Single request into an idle pipeline with literal expectations and exact 2-edge latency.
    task automatic one(input string nm, input logic [2:0] op, input logic [31:0] imm, input logic [31:0] base,
                       input logic [31:0] want_inst, input logic want_err);
        logic [32:0] m;
        logic [15:0] e0;
        e0 = err_cnt;
        m  = model(op, imm, base);
        chk({nm, "_model_inst"}, m[31:0], want_inst);
        chk({nm, "_model_err"}, {31'd0, m[32]}, {31'd0, want_err});
        send(op, imm, base);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_inst"}, out_inst, want_inst);
        chk({nm, "_err"}, {31'd0, out_err}, {31'd0, want_err});
        @(posedge clk);
        #1;
        chk({nm, "_errcnt"}, {16'd0, err_cnt}, {16'd0, e0 + {15'd0, want_err}});
    endtask

    typedef struct { logic [2:0] op; logic [31:0] imm; logic [31:0] base; } vec_t;
    vec_t vecs[18] = '{
        '{3'd0, 32'd2047,     32'hA5A5A5A5}, '{3'd0, 32'd2048,     32'h5A5A5A5A},
        '{3'd0, 32'hFFFFF800, 32'hA5A5A5A5}, '{3'd0, 32'hFFFFF7FF, 32'h5A5A5A5A},
        '{3'd2, 32'd2047,     32'hA5A5A5A5}, '{3'd2, 32'h00000800, 32'h5A5A5A5A},
        '{3'd3, 32'd4094,     32'hA5A5A5A5}, '{3'd3, 32'd4096,     32'h5A5A5A5A},
        '{3'd3, 32'hFFFFF000, 32'hA5A5A5A5}, '{3'd3, 32'd1,        32'h5A5A5A5A},
        '{3'd4, 32'h000FFFFE, 32'hA5A5A5A5}, '{3'd4, 32'h00100000, 32'h5A5A5A5A},
        '{3'd4, 32'hFFF00000, 32'hA5A5A5A5}, '{3'd1, 32'hFFFFF000, 32'h5A5A5A5A},
        '{3'd1, 32'h00000800, 32'hA5A5A5A5}, '{3'd5, 32'h12345678, 32'h5A5A5A5A},
        '{3'd6, 32'h0,        32'hA5A5A5A5}, '{3'd7, 32'hFFFFFFFF, 32'hCAFEF00D}
    };

    initial begin
        logic [7:0] pat;
        logic [15:0] e0;
        rst = 1'b1; in_valid = 1'b0; in_extop = 3'd0; in_imm = 32'h0; in_base = 32'h0; out_ready = 1'b1;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        one("i_min",   3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0);
        one("b_neg4",  3'd3, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0);
        one("j_odd",   3'd4, 32'h00000003, 32'h0000006F, 32'h0020006F, 1'b1);
        one("u_ok",    3'd1, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
        one("u_low",   3'd1, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1);
        one("s_neg1",  3'd2, 32'hFFFFFFFF, 32'h00002023, 32'hFE002FA3, 1'b0);
        one("resv",    3'd6, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        one("j_max",   3'd4, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0);

        // Boundary table under an irregular consumer.
        pat = 8'b1011_0010;
        fork
            begin
                foreach (vecs[i]) send(vecs[i].op, vecs[i].imm, vecs[i].base);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk);
                    #1 out_ready = pat[k % 8];
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("table_drained", q.size(), 32'd0);

        // Stalled consumer: two requests fill the pipe, the third waits.
        e0 = enc_cnt;
        fork
            begin
                send(3'd0, 32'd1, 32'h00000013);
                send(3'd0, 32'd2, 32'h00000013);
                send(3'd0, 32'd3, 32'h00000013);
            end
            begin
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_held", q.size(), 32'd2);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("stall_count", {16'd0, enc_cnt - e0}, 32'd3);

        // Back-to-back stream of 8.
        do_reset();
        for (int i = 0; i < 8; i++) send(3'(i % 5), 32'(i * 4), 32'h00000033);
        repeat (3) @(posedge clk);
        #1 chk("stream_enc_cnt", {16'd0, enc_cnt}, 32'd8);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        send(3'd0, 32'd5, 32'h13);
        send(3'd0, 32'd6, 32'h13);
        do_reset();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("midrst_no_output", {16'd0, enc_cnt}, 32'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ysyx_24100027_imm_enc.md
YSYX_24100027_IMM_ENC -- requirements
Module: ysyx_24100027_IMM_ENC

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_extop  input  3  format: 000 I, 001 U, 010 S, 011 B, 100 J; 101-111 reserved.
REQ-007 in_imm  input  32  signed immediate to encode (byte offset for B/J).
REQ-008 in_base  input  32  instruction template (opcode, rd, rs1, rs2, funct3, funct7); its imm-field bits are overwritten.
REQ-009 out_valid  output  1  encoded instruction valid.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_inst  output  32  packed instruction.
REQ-012 out_err  output  1  immediate out of range, misaligned, or extop reserved.
REQ-013 enc_cnt  output  16  count of output handshakes, saturating.
REQ-014 err_cnt  output  16  count of output handshakes with out_err=1, saturating.

Function
REQ-015 A handshake SHALL occur on the rising edge where valid and ready are both high, on either port.
REQ-016 The datapath SHALL be a 2-stage pipeline: stage S1 registers the request; stage S2 registers the packed result and the error flag.
REQ-017 Latency SHALL be 2 cycles from input handshake to out_valid=1, with throughput of 1 per cycle when out_ready=1.
REQ-018 Each stage SHALL advance only when the next stage is empty or is being drained in the same cycle.
REQ-019 in_ready SHALL be computed as !s1_valid || (!s2_valid || out_ready).
REQ-020 When out_valid=1 and out_ready=0, out_inst and out_err SHALL hold stable; once 2 requests are held, in_ready SHALL be 0.
REQ-021 Packing by format; bits not listed SHALL come from in_base:
  - I: inst[31:20]=imm[11:0].
  - U: inst[31:12]=imm[31:12].
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
REQ-022 Error rules:
  - I and S SHALL flag an error unless imm equals the sign-extension of imm[11:0].
  - U SHALL flag an error if imm[11:0] is not 0.
  - B SHALL flag an error unless imm[0]=0 and imm equals the sign-extension of imm[12:0].
  - J SHALL flag an error unless imm[0]=0 and imm equals the sign-extension of imm[20:0].
REQ-023 On an error the truncated bits SHALL still be packed; a reserved extop SHALL output in_base unchanged with out_err=1.
REQ-024 enc_cnt SHALL increment on each output handshake and err_cnt on each output handshake with out_err=1; both SHALL saturate at 0xFFFF.
REQ-025 A simultaneous input and output handshake SHALL keep the pipeline full with no bubble and no loss.

Reset
REQ-026 With rst=1 at a clock edge:
  - s1_valid, s2_valid, out_valid, enc_cnt and err_cnt SHALL be 0.
  - out_inst and out_err SHALL be 0.
  - in_ready SHALL be 1 from the first cycle after reset.
REQ-027 A reset asserted mid-operation SHALL discard in-flight requests without producing any output handshake.

Verification
REQ-028 I, imm=0xFFFFF800, base=0x00000013 -> out_inst=0x80000013, out_err=0, 2 cycles after accept.
REQ-029 B, imm=0xFFFFFFFC, base=0x00000063 -> out_inst=0xFE000EE3, out_err=0; J, imm=3 -> out_err=1, err_cnt increments.
REQ-030 U, imm=0x12345000, base=0x00000037 -> 0x12345037; U, imm=0x12345001 -> out_err=1 with the same out_inst.
REQ-031 out_ready=0 for 4 cycles while 3 requests are offered -> 2 are accepted and the third waits with in_ready=0; on release, outputs appear in order with no loss or duplication.
REQ-032 Back-to-back stream of 8 requests with out_ready=1 -> 8 outputs on consecutive cycles, enc_cnt=8.
REQ-033 rst pulsed while 2 requests are in flight -> out_valid=0 the next cycle and enc_cnt=0; no output handshake for the dropped requests.
